pc_sequencer: RTL and testbench

//  Fetch/execute sequencer that drives the n-bit program counter's ctrl/load/clear inputs.

---
 rtl/pc_defs_pkg.sv | 28 ++
 rtl/pc_seq_timeout.sv | 26 ++
 rtl/pc_sequencer.sv | 149 ++++++++++++++
 tb/tb_pc_sequencer.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/pc_defs_pkg.sv
// Shared encodings for the fetch/execute sequencer: FSM states, PC control
// codes and next-PC selector codes.
package pc_defs;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_WAIT   = 3'd2,
        S_EXEC   = 3'd3,
        S_UPDATE = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        PC_HOLD = 2'b00,
        PC_LOAD = 2'b01,
        PC_INC1 = 2'b10,
        PC_INCN = 2'b11
    } pc_ctrl_t;

    typedef enum logic [1:0] {
        NXT_SEQ  = 2'b00,
        NXT_BR   = 2'b01,
        NXT_SKIP = 2'b10,
        NXT_HALT = 2'b11
    } nxt_sel_t;

endpackage

// File: rtl/pc_seq_timeout.sv
// WAIT-cycle counter: cleared on load, advanced on inc, flags the cycle whose
// increment would reach TMO.
module pc_seq_timeout #(
    parameter int unsigned TMO = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic inc,
    output logic expire_c
);

    localparam int unsigned CW = $clog2(TMO + 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)       cnt <= '0;
        else if (load) cnt <= '0;
        else if (inc)  cnt <= cnt + CW'(1);
    end

    // Expiring here makes the TMO-th consecutive un-acked WAIT cycle the last one.
    assign expire_c = (cnt == CW'(TMO - 1));

endmodule

// File: rtl/pc_sequencer.sv
// Fetch/execute sequencer driving the program counter's clear/ctrl/load inputs,
// the instruction-fetch handshake and the handoff to the execute stage.
module pc_sequencer
    import pc_defs::*;
#(
    parameter int unsigned   N       = 8,
    parameter int unsigned   IW      = 16,
    parameter logic [N-1:0]  IRQ_VEC = N'(8'h10),
    parameter int unsigned   TMO     = 15,
    parameter int unsigned   CNT_W   = 16
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             start,
    output logic             imem_req,
    input  logic             imem_ack,
    input  logic [IW-1:0]    imem_data,
    output logic [IW-1:0]    instr_q,
    output logic             instr_valid,
    input  logic             exec_done,
    input  logic [1:0]       nxt_sel,
    input  logic [N-1:0]     nxt_target,
    input  logic             irq,
    input  logic             irq_en,
    output logic             pc_clr_n,
    output logic [1:0]       pc_ctrl,
    output logic [N-1:0]     pc_load,
    output logic             halted,
    output logic             fault,
    output logic [CNT_W-1:0] retired
);

    state_t         state_q, state_d;
    nxt_sel_t       sel_q;
    logic [N-1:0]   tgt_q;
    logic           first_q;
    logic           irq_pend;

    logic           tmo_load, tmo_inc, tmo_expire;
    logic           cap_instr, cap_nxt, set_fault, retire, take;

    pc_seq_timeout #(.TMO(TMO)) u_tmo (
        .clk      (clk),
        .rst      (clr),
        .load     (tmo_load),
        .inc      (tmo_inc),
        .expire_c (tmo_expire)
    );

    always_ff @(posedge clk or posedge clr) begin
        if (clr) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Next state and Moore output decode; irq_en is sampled only in UPDATE.
    always_comb begin
        state_d     = state_q;
        imem_req    = 1'b0;
        instr_valid = 1'b0;
        pc_clr_n    = 1'b1;
        pc_ctrl     = PC_HOLD;
        pc_load     = '0;
        halted      = 1'b0;
        tmo_load    = 1'b0;
        tmo_inc     = 1'b0;
        cap_instr   = 1'b0;
        cap_nxt     = 1'b0;
        set_fault   = 1'b0;
        retire      = 1'b0;
        take        = 1'b0;
        case (state_q)
            S_IDLE: begin
                pc_clr_n = 1'b0;
                if (start) state_d = S_FETCH;
            end
            S_FETCH: begin
                imem_req = 1'b1;
                tmo_load = 1'b1;
                state_d  = S_WAIT;
            end
            S_WAIT: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    cap_instr = 1'b1;
                    state_d   = S_EXEC;
                end else if (tmo_expire) begin
                    set_fault = 1'b1;
                    state_d   = S_HALT;
                end else begin
                    tmo_inc = 1'b1;
                end
            end
            S_EXEC: begin
                instr_valid = first_q;
                if (exec_done) begin
                    cap_nxt = 1'b1;
                    state_d = S_UPDATE;
                end
            end
            S_UPDATE: begin
                retire  = 1'b1;
                state_d = S_FETCH;
                if (sel_q == NXT_HALT) begin
                    state_d = S_HALT;
                end else if (irq_pend && irq_en) begin
                    pc_ctrl = PC_LOAD;
                    pc_load = IRQ_VEC;
                    take    = 1'b1;
                end else if (sel_q == NXT_BR) begin
                    pc_ctrl = PC_LOAD;
                    pc_load = tgt_q;
                end else if (sel_q == NXT_SKIP) begin
                    pc_ctrl = PC_INCN;
                end else begin
                    pc_ctrl = PC_INC1;
                end
            end
            S_HALT: begin
                halted = 1'b1;
                if (start) state_d = S_FETCH;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Capture registers, sticky fault, pending interrupt and retired count.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            instr_q  <= '0;
            first_q  <= 1'b0;
            sel_q    <= NXT_SEQ;
            tgt_q    <= '0;
            irq_pend <= 1'b0;
            fault    <= 1'b0;
            retired  <= '0;
        end else begin
            first_q  <= cap_instr;
            irq_pend <= irq | (irq_pend & ~take);
            if (cap_instr) instr_q <= imem_data;
            if (cap_nxt) begin
                sel_q <= nxt_sel_t'(nxt_sel);
                tgt_q <= nxt_target;
            end
            if (set_fault) fault   <= 1'b1;
            if (retire)    retired <= retired + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Randomized self-checking bench for pc_sequencer with a behavioural PC and
// an instruction-level reference model.
module tb_pc_sequencer;

    localparam logic [7:0] IRQ_VEC = 8'h10;

    logic        clk, clr, start;
    logic        imem_req, imem_ack;
    logic [15:0] imem_data, instr_q;
    logic        instr_valid, exec_done;
    logic [1:0]  nxt_sel;
    logic [7:0]  nxt_target;
    logic        irq, irq_en;
    logic        pc_clr_n;
    logic [1:0]  pc_ctrl;
    logic [7:0]  pc_load;
    logic        halted, fault;
    logic [15:0] retired;

    pc_sequencer #(.N(8), .IW(16), .IRQ_VEC(IRQ_VEC), .TMO(15), .CNT_W(16)) dut (
        .clk(clk), .clr(clr), .start(start),
        .imem_req(imem_req), .imem_ack(imem_ack), .imem_data(imem_data),
        .instr_q(instr_q), .instr_valid(instr_valid),
        .exec_done(exec_done), .nxt_sel(nxt_sel), .nxt_target(nxt_target),
        .irq(irq), .irq_en(irq_en),
        .pc_clr_n(pc_clr_n), .pc_ctrl(pc_ctrl), .pc_load(pc_load),
        .halted(halted), .fault(fault), .retired(retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in for the n-bit PC (inc=2) driven by the sequencer.
    logic [7:0] pc;
    always_ff @(posedge clk) begin
        if (!pc_clr_n) pc <= 8'd0;
        else case (pc_ctrl)
            2'b01:   pc <= pc_load;
            2'b10:   pc <= pc + 8'd1;
            2'b11:   pc <= pc + 8'd2;
            default: pc <= pc;
        endcase
    end

    int unsigned cyc = 0;
    always_ff @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0]  exp_pc;
    logic [15:0] exp_retired;
    logic        exp_pend, exp_fault;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One full instruction starting in FETCH; the model applies the next-PC rules.
    task automatic run_instr(input logic [1:0] sel, input logic [7:0] tgt,
                             input int ack_dly, input int n_exec,
                             input logic irq_ex, input logic irq_upd, input logic en);
        int unsigned c0;
        logic [15:0] d;
        c0     = cyc;
        irq_en = en;
        d      = 16'($urandom);
        check("fetch_req", 32'(imem_req), 32'd1);
        step();
        for (int k = 0; k < ack_dly; k++) step();
        check("wait_req", 32'(imem_req), 32'd1);
        imem_ack  = 1'b1;
        imem_data = d;
        step();
        imem_ack = 1'b0;
        check("instr_valid_first", 32'(instr_valid), 32'd1);
        check("instr_q", 32'(instr_q), 32'(d));
        for (int j = 1; j <= n_exec; j++) begin
            if (j > 1) check("instr_valid_later", 32'(instr_valid), 32'd0);
            if (j == 1 && irq_ex) irq = 1'b1;
            if (j == n_exec) begin
                exec_done  = 1'b1;
                nxt_sel    = sel;
                nxt_target = tgt;
            end
            step();
            irq       = 1'b0;
            exec_done = 1'b0;
        end
        if (irq_ex) exp_pend = 1'b1;
        if (irq_upd) irq = 1'b1;
        step();
        irq = 1'b0;
        exp_retired = exp_retired + 16'd1;
        if (sel != 2'b11) begin
            if (exp_pend && en) begin
                exp_pc   = IRQ_VEC;
                exp_pend = 1'b0;
            end else if (sel == 2'b01) exp_pc = tgt;
            else if (sel == 2'b10)     exp_pc = exp_pc + 8'd2;
            else                       exp_pc = exp_pc + 8'd1;
        end
        if (irq_upd) exp_pend = 1'b1;
        check("instr_cycles", cyc - c0, 32'(3 + ack_dly + n_exec));
        check("pc", 32'(pc), 32'(exp_pc));
        check("retired", 32'(retired), 32'(exp_retired));
        check("halted", 32'(halted), 32'(sel == 2'b11));
        check("req_after", 32'(imem_req), 32'(sel != 2'b11));
        check("fault", 32'(fault), 32'(exp_fault));
    endtask

    task automatic resume();
        start = 1'b1;
        step();
        start = 1'b0;
        check("resume_req", 32'(imem_req), 32'd1);
        check("resume_halted", 32'(halted), 32'd0);
        check("resume_pc", 32'(pc), 32'(exp_pc));
    endtask

    task automatic model_reset();
        exp_pc = 8'd0; exp_retired = 16'd0; exp_pend = 1'b0; exp_fault = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req"}, 32'(imem_req), 32'd0);
        check({tag, "_valid"}, 32'(instr_valid), 32'd0);
        check({tag, "_ctrl"}, 32'(pc_ctrl), 32'd0);
        check({tag, "_load"}, 32'(pc_load), 32'd0);
        check({tag, "_clr_n"}, 32'(pc_clr_n), 32'd0);
        check({tag, "_halted"}, 32'(halted), 32'd0);
        check({tag, "_fault"}, 32'(fault), 32'd0);
        check({tag, "_retired"}, 32'(retired), 32'd0);
        check({tag, "_instr_q"}, 32'(instr_q), 32'd0);
    endtask

    initial begin
        int k;
        clr = 1'b1; start = 1'b0; imem_ack = 1'b0; imem_data = 16'd0;
        exec_done = 1'b0; nxt_sel = 2'b00; nxt_target = 8'd0; irq = 1'b0; irq_en = 1'b0;
        model_reset();
        step(); step();
        check_reset_outputs("reset");
        clr = 1'b0;
        step();
        check("idle_pc", 32'(pc), 32'd0);
        check("idle_req", 32'(imem_req), 32'd0);

        // Sequential, branch, skip
        start = 1'b1; step(); start = 1'b0;
        check("start_pc", 32'(pc), 32'd0);
        for (int i = 0; i < 3; i++) run_instr(2'b00, 8'h00, 0, 2, 1'b0, 1'b0, 1'b0);
        run_instr(2'b01, 8'h40, 0, 2, 1'b0, 1'b0, 1'b0);
        run_instr(2'b10, 8'h00, 1, 3, 1'b0, 1'b0, 1'b0);

        // Interrupt taken, then masked (stays pending), then taken later
        run_instr(2'b01, 8'h40, 0, 2, 1'b1, 1'b0, 1'b1);
        run_instr(2'b01, 8'h40, 0, 2, 1'b1, 1'b0, 1'b0);
        run_instr(2'b00, 8'h00, 0, 2, 1'b0, 1'b0, 1'b1);
        // Same-cycle set and take keeps it pending
        run_instr(2'b00, 8'h00, 0, 2, 1'b1, 1'b1, 1'b1);
        run_instr(2'b01, 8'h20, 0, 2, 1'b0, 1'b0, 1'b1);

        // Halt at pc=5 and resume without clearing the PC
        run_instr(2'b01, 8'h05, 0, 2, 1'b0, 1'b0, 1'b1);
        run_instr(2'b11, 8'h00, 0, 2, 1'b0, 1'b0, 1'b1);
        step();
        check("halt_hold_pc", 32'(pc), 32'd5);
        resume();

        // Fetch timeout: HALT after 15 un-acked WAIT cycles
        k = 0;
        while (k < 40 && !halted) begin
            step();
            k++;
            if (k == 15) check("tmo_fault_early", 32'(fault), 32'd0);
        end
        exp_fault = 1'b1;
        check("tmo_cycles", 32'(k), 32'd16);
        check("tmo_fault", 32'(fault), 32'd1);
        check("tmo_req", 32'(imem_req), 32'd0);
        check("tmo_pc", 32'(pc), 32'(exp_pc));
        resume();
        run_instr(2'b00, 8'h00, 2, 2, 1'b0, 1'b0, 1'b0);

        // Asynchronous reset in the middle of EXEC
        step();
        imem_ack = 1'b1; imem_data = 16'hA5A5;
        step();
        imem_ack = 1'b0;
        check("pre_reset_valid", 32'(instr_valid), 32'd1);
        #2 clr = 1'b1;
        #1 check_reset_outputs("async");
        #1 clr = 1'b0;
        model_reset();
        step();
        check("post_reset_pc", 32'(pc), 32'd0);
        check("post_reset_clr_n", 32'(pc_clr_n), 32'd0);

        // Randomized instruction stream
        start = 1'b1; step(); start = 1'b0;
        for (int i = 0; i < 60; i++) begin
            int r;
            logic [1:0] s;
            r = int'($urandom_range(0, 9));
            s = (r == 0) ? 2'b11 : 2'(r % 3);
            run_instr(s, 8'($urandom), int'($urandom_range(0, 3)), int'($urandom_range(2, 4)),
                      1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 7) == 0),
                      1'($urandom_range(0, 1)));
            if (s == 2'b11) begin
                step();
                resume();
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
